// File: rtl/ms_pkg.sv
// ms_pkg: shared sizes, FSM states and BCD vector type for the multiplier/BCD datapath.
package ms_pkg;

    localparam int DW = 8;
    localparam int PW = 2 * DW + 1;
    localparam int ND = 6;

    typedef enum logic [1:0] {IDLE, CONV, LOAD} bcd_state_t;

    typedef logic [4*ND-1:0] bcd_t;

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: double-dabble correction cell, adds 3 to a digit of 5 or more.
module bcd_digit_adj (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/product_bcd.sv
// product_bcd: captures the multiplier product on its done pulse and converts it
// to packed BCD with a bit-serial shift-and-add-3 loop.
module product_bcd
    import ms_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [PW-1:0] i_product,
    output bcd_t          o_bcd,
    output logic          o_busy,
    output logic          o_done
);

    localparam int CW = $clog2(PW + 1);

    if (pow10(ND) <= (64'd1 << PW)) begin : g_capacity_check
        $error("product_bcd: ND digits cannot hold a PW-bit product");
    end

    bcd_state_t      r_state;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   r_bin;
    bcd_t            r_scratch;
    bcd_t            r_bcd;
    logic            r_busy;
    logic            r_done;
    bcd_t            w_adj;
    bcd_t            w_shifted;
    logic            w_unused_msb;

    genvar g;
    for (g = 0; g < ND; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (r_scratch[4*g +: 4]),
            .o_digit (w_adj[4*g +: 4])
        );
    end

    // Top digit never carries out because the digit count covers the full product range.
    assign {w_unused_msb, w_shifted} = {w_adj, r_bin[PW-1]};

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bin     <= '0;
            r_scratch <= '0;
            r_bcd     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (i_start) begin
                    r_bin     <= i_product;
                    r_scratch <= '0;
                    r_cnt     <= CW'(PW);
                    r_busy    <= 1'b1;
                    r_state   <= CONV;
                end
                CONV: begin
                    r_scratch <= w_shifted;
                    r_bin     <= {r_bin[PW-2:0], 1'b0};
                    r_cnt     <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) r_state <= LOAD;
                end
                LOAD: begin
                    r_bcd   <= r_scratch;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_bcd  = r_bcd;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: tb/tb_product_bcd.sv
// tb_product_bcd: directed and random checks of product_bcd against a decimal-digit model.
module tb_product_bcd;
    import ms_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [PW-1:0] product = '0;
    bcd_t          bcd;
    logic          busy;
    logic          done;
    int            n_checks = 0;
    int            n_errors = 0;

    product_bcd dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .i_product (product),
        .o_bcd     (bcd),
        .o_busy    (busy),
        .o_done    (done)
    );

    always #5 clk = ~clk;

    function automatic bcd_t to_bcd(input int unsigned v);
        bcd_t r;
        r = '0;
        for (int d = 0; d < ND; d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a start pulse so that it is sampled at the next rising edge.
    task automatic launch(input logic [PW-1:0] p);
        start   = 1'b1;
        product = p;
        @(posedge clk);
        #1;
        start   = 1'b0;
        product = PW'($urandom);
    endtask

    task automatic wait_done(output int n, output int nbusy);
        n = 0;
        nbusy = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy) nbusy++;
        end while (!done && n < 60);
    endtask

    task automatic expect_result(input string tag, input logic [PW-1:0] p);
        int n, nb;
        wait_done(n, nb);
        chk({tag, "_latency"}, 32'(n - 1), 32'd18);
        chk({tag, "_busy_cycles"}, 32'(nb), 32'd18);
        chk({tag, "_bcd"}, 32'(bcd), 32'(to_bcd(32'(p))));
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int nd;
        nd = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk({tag, "_no_done"}, 32'(nd), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n, nb;
        logic [PW-1:0] v;
        #1;
        chk("reset_bcd", 32'(bcd), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        launch(17'd0);
        expect_result("zero", 17'd0);
        @(negedge clk);
        chk("done_pulse_width", 32'(done), 32'd0);

        launch(17'd65025);
        expect_result("sq255", 17'd65025);
        launch(17'd131071);
        expect_result("all_ones", 17'd131071);
        launch(17'd9);
        expect_result("nine", 17'd9);
        @(negedge clk);

        launch(17'd4321);
        repeat (4) @(negedge clk);
        launch(17'd1234);
        wait_done(n, nb);
        chk("ignore_latency", 32'(n - 1), 32'd14);
        chk("ignore_bcd", 32'(bcd), 32'(to_bcd(4321)));
        expect_quiet("ignore", 30);

        launch(17'd99);
        expect_result("b2b_first", 17'd99);
        launch(17'd100);
        expect_result("b2b_second", 17'd100);
        @(negedge clk);

        launch(17'd777);
        repeat (9) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midreset_bcd", 32'(bcd), 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        expect_quiet("after_reset", 30);
        launch(17'd42);
        expect_result("after_reset_42", 17'd42);

        for (int i = 0; i < 12; i++) begin
            v = PW'($urandom_range(0, 131071));
            launch(v);
            expect_result("random", v);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/product_bcd.md
# product_bcd

Sequential binary-to-BCD converter that sits directly downstream of the shift-add multiplier. It captures the multiplier's unsigned product on the multiplier's completion pulse and converts it using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It presents a registered packed-BCD result with a one-cycle done pulse for the display or readout stage.

## Interface
- DW, 8, operand width of the upstream multiplier.
- PW, 2*DW+1, product width; must match the multiplier product port width.
- ND, 6, number of BCD digits; 10^ND must exceed 2^PW (checked by elaboration assertion).
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  reset, asynchronous, active-low.
- i_start  input  1  capture strobe; connect to the multiplier's completion pulse.
- i_product  input  PW  unsigned product, valid in the cycle i_start is high.
- o_bcd  output  4*ND  packed BCD result, digit 0 in bits [3:0]; registered.
- o_busy  output  1  high while a conversion is in progress.
- o_done  output  1  one-cycle pulse when o_bcd has been updated.

## Operation
- FSM states: IDLE, CONV, LOAD. Reset state is IDLE.
- IDLE:
  - If i_start = 1: load i_product into the binary shift register, clear the ND-digit scratch register, and set the step counter to PW.
  - Then go to CONV.
- CONV, each cycle:
  - Correct every scratch digit: if the digit is 5 or more, add 3 (4-bit result, no carry out).
  - Shift {scratch, binary} left by 1 and decrement the counter.
  - When the counter reaches 1 on this step (PW steps done), go to LOAD.
- LOAD:
  - o_bcd <= scratch, o_done <= 1, go to IDLE.
- o_busy is high in CONV and LOAD.
- Arithmetic:
  - Unsigned only.
  - Digits never exceed 9 after the final shift.
  - No overflow flag is needed, because the ND constraint guarantees capacity.
- i_start while not in IDLE is ignored. The running conversion is not disturbed and the input is not queued.
- o_bcd holds the last completed result until the next LOAD.

## Timing
- Reset (asserted, asynchronous): o_bcd = 0, o_busy = 0, o_done = 0, state = IDLE, counter = 0, scratch = 0.
- Reset mid-conversion: the conversion is aborted immediately, with no o_done and o_bcd = 0. After release the block sits in IDLE.
- Edge numbering:
  - i_start is sampled high at edge E0.
  - Conversion steps occur at edges E1 through E_PW.
  - LOAD occurs at edge E_PW+1.
- o_done is high for exactly the cycle following E_PW+1. Latency from the i_start edge to o_done is PW+1 cycles (18 cycles at defaults).
- o_busy rises after E0 and falls after E_PW+1.
- Back-to-back: the block is in IDLE during the o_done cycle, so an i_start in that cycle is accepted.
- i_product only needs to be stable in the i_start cycle; it is not re-read afterwards.

## Structure
- Shared package ms_pkg:
  - Localparams DW, PW, ND.
  - Typedef enum logic [1:0] {IDLE, CONV, LOAD} bcd_state_t.
  - Typedef for the packed BCD vector, logic [4*ND-1:0].
- Sub-module bcd_digit_adj: 4-bit combinational add-3-if-≥5 cell, instantiated ND times through a generate loop.
- Top level: FSM, counter of width $clog2(PW+1), PW-bit binary shift register, 4*ND-bit scratch register, output register.

## Test plan
- Reset, then i_product = 0 with a start pulse -> o_done after 18 cycles, o_bcd = 0x000000.
- i_product = 65025 (255×255) -> o_bcd = 0x065025 with o_done on cycle 18. o_busy is high for exactly 18 cycles.
- i_product = 131071 (all ones) -> 0x131071. Then i_product = 9 -> 0x000009. Verifies digit correction at the full-width boundary.
- i_start pulsed again at cycle 5 with i_product = 1234 during the conversion of 4321 -> a single o_done with 0x004321. No second conversion follows.
- Back-to-back: second i_start in the o_done cycle with 100 after 99 -> 0x000099, then 0x000100 exactly 18 cycles later.
- i_rst asserted at cycle 10 of a conversion -> all outputs 0 immediately and no o_done. A fresh start after release with 42 -> 0x000042.
